// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send and
// shifts one odd-parity byte out on device-generated clock edges, then checks the ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int FIRST_TIMEOUT  = 750000,
  parameter int EDGE_TIMEOUT   = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] send_data,
  input  logic       send_req,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_WAIT_FIRST,
    S_SHIFT,
    S_WAIT_IDLE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] FIRST_LAST   = 20'(FIRST_TIMEOUT - 1);
  localparam logic [19:0] EDGE_LAST    = 20'(EDGE_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic        parity_q, parity_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [19:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        clk_oe_q, clk_oe_d;
  logic        data_oe_q, data_oe_d;

  logic        clk_meta_q, clk_sync_q, clk_prev_q;
  logic        data_meta_q, data_sync_q;
  logic        fall_s;
  logic [3:0]  next_bit_s;

  // Synchronizers idle high so reset release never fakes a falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall_s     = clk_prev_q & ~clk_sync_q;
  assign next_bit_s = bit_cnt_q + 4'd1;

  // State, datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      data_q    <= 8'h00;
      parity_q  <= 1'b0;
      bit_cnt_q <= 4'd0;
      cnt_q     <= 20'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register with it.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q + 20'd1;
    data_oe_d = data_oe_q;

    case (state_q)
      S_IDLE: begin
        cnt_d     = 20'd0;
        data_oe_d = 1'b0;
        if (send_req) begin
          data_d    = send_data;
          parity_d  = ~^send_data;
          bit_cnt_d = 4'd0;
          state_d   = S_INHIBIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          cnt_d     = 20'd0;
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          state_d = S_INHIBIT;
        end
      end
      S_REQ: begin
        cnt_d     = 20'd0;
        data_oe_d = 1'b1;
        state_d   = S_WAIT_FIRST;
      end
      S_WAIT_FIRST: begin
        if (fall_s) begin
          cnt_d     = 20'd0;
          bit_cnt_d = 4'd1;
          data_oe_d = ~data_q[0];
          state_d   = S_SHIFT;
        end else if (cnt_q == FIRST_LAST) begin
          data_oe_d = 1'b0;
          state_d   = S_ERR;
        end else begin
          state_d = S_WAIT_FIRST;
        end
      end
      S_SHIFT: begin
        if (fall_s) begin
          cnt_d     = 20'd0;
          bit_cnt_d = next_bit_s;
          case (next_bit_s)
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: data_oe_d = ~data_q[bit_cnt_q[2:0]];
            4'd9:  data_oe_d = ~parity_q;
            4'd10: data_oe_d = 1'b0;
            4'd11: begin
              // Edge 11 carries the device ack: data must be held low.
              data_oe_d = 1'b0;
              state_d   = data_sync_q ? S_ERR : S_WAIT_IDLE;
            end
            default: begin
              data_oe_d = 1'b0;
              state_d   = S_ERR;
            end
          endcase
        end else if (cnt_q == EDGE_LAST) begin
          data_oe_d = 1'b0;
          state_d   = S_ERR;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_WAIT_IDLE: begin
        data_oe_d = 1'b0;
        if (clk_sync_q && data_sync_q) begin
          state_d = S_DONE;
        end else if (cnt_q == EDGE_LAST) begin
          state_d = S_ERR;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      S_DONE, S_ERR: begin
        cnt_d     = 20'd0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        cnt_d     = 20'd0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
    busy_d   = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
    done_d   = (state_d == S_DONE);
    error_d  = (state_d == S_ERR);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-drain PS/2 device model (scaled clock rate).
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH = 10;
  localparam int FT  = 50;
  localparam int ET  = 100;
  localparam int H   = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] send_data;
  logic       send_req;
  logic       busy, done, error, clk_oe, data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       clk_line, data_line;

  assign clk_line  = ~clk_oe & dev_clk;
  assign data_line = ~data_oe & dev_data;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .FIRST_TIMEOUT(FT), .EDGE_TIMEOUT(ET)) dut (
    .clock(clock), .reset(reset), .send_data(send_data), .send_req(send_req),
    .busy(busy), .done(done), .error(error),
    .ps2_clk_in(clk_line), .ps2_data_in(data_line),
    .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe));

  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int n_resp = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    logic       par;
    int         exp_cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] cap_byte;
  logic       cap_par, cap_start, cap_stop;
  bit         frame_active = 1'b0;
  bit         busy_gap = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done/error pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && (done || error)) begin
        check("done_error_exclusive", done & error, 0);
        check("response_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("resp_kind_error", error, e.is_err);
          check("busy_low_at_resp", busy, 0);
          check("busy_held_in_frame", busy_gap, 0);
          if (e.exp_cyc >= 0) check("resp_cycle", cyc, e.exp_cyc);
          if (error) begin
            check("clk_oe_after_err", clk_oe, 0);
            check("data_oe_after_err", data_oe, 0);
          end else begin
            check("dev_start_bit", cap_start, 0);
            check("dev_byte", cap_byte, e.data);
            check("dev_parity", cap_par, e.par);
            check("dev_stop_bit", cap_stop, 1);
          end
        end
        frame_active = 1'b0;
        busy_gap = 1'b0;
        n_resp++;
      end else if (frame_active && !busy) begin
        busy_gap = 1'b1;
      end
    end
  end

  // mode: 0 ack, 1 no ack, 2 never clocks, 3 stops after edge 5
  task automatic device(input int mode);
    int t;
    t = 0;
    while (!(clk_line && !data_line) && t < 500) begin
      @(negedge clock);
      t++;
    end
    check("dev_saw_request", clk_line && !data_line, 1);
    if (mode == 2) return;
    cap_start = data_line;
    repeat (10) @(negedge clock);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        if (mode == 0) dev_data = 1'b0;
        repeat (5) @(negedge clock);
      end
      dev_clk = 1'b0;
      if (mode == 3 && k == 5) begin
        repeat (6) @(negedge clock);
        return;
      end
      repeat (H) @(negedge clock);
      dev_clk = 1'b1;
      if (k <= 8) cap_byte[k-1] = data_line;
      else if (k == 9) cap_par = data_line;
      else if (k == 10) cap_stop = data_line;
      if (k == 11) begin
        repeat (5) @(negedge clock);
        dev_data = 1'b1;
      end
      repeat (H) @(negedge clock);
    end
  endtask

  task automatic spam_requests();
    int t;
    t = 0;
    while (busy && t < 5000) begin
      send_data = 8'h55;
      send_req = 1'b1;
      @(negedge clock);
      send_req = 1'b0;
      repeat (3) @(negedge clock);
      t += 4;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic par, input int mode, input bit spam);
    int c0, r0, t;
    exp_t e;
    @(negedge clock);
    send_data = b;
    send_req = 1'b1;
    c0 = cyc;
    r0 = n_resp;
    if (mode != 3) begin
      e.is_err  = (mode == 1) || (mode == 2);
      e.data    = b;
      e.par     = par;
      e.exp_cyc = (mode == 2) ? c0 + INH + 2 + FT : -1;
      exp_q.push_back(e);
    end
    for (int n = 1; n <= INH + 2; n++) begin
      @(negedge clock);
      if (n == 1) begin
        send_req = 1'b0;
        frame_active = 1'b1;
      end
      check("busy_in_setup", busy, 1);
      check("clk_oe_setup", clk_oe, (n <= INH + 1) ? 1 : 0);
      check("data_oe_setup", data_oe, (n >= INH + 1) ? 1 : 0);
    end
    fork
      device(mode);
      if (spam) spam_requests();
    join
    if (mode != 3) begin
      t = 0;
      while (n_resp == r0 && t < 3000) begin
        @(negedge clock);
        t++;
      end
      check("response_seen", n_resp != r0, 1);
      repeat (5) @(negedge clock);
    end
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    send_req = 1'b0;
    send_data = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_clk_oe", clk_oe, 0);
    check("rst_data_oe", data_oe, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    send(8'hED, 1'b1, 0, 1'b0);
    send(8'h01, 1'b0, 0, 1'b0);
    send(8'h00, 1'b1, 0, 1'b0);
    send(8'hFF, 1'b1, 0, 1'b0);
    send(8'hED, 1'b1, 1, 1'b0);
    send(8'h3C, 1'b1, 2, 1'b0);
    send(8'hED, 1'b1, 0, 1'b1);

    send(8'hED, 1'b1, 3, 1'b0);
    check("abort_busy_before_reset", busy, 1);
    check("abort_data_oe_before_reset", data_oe, 1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_error", error, 0);
    check("abort_clk_oe", clk_oe, 0);
    check("abort_data_oe", data_oe, 0);
    frame_active = 1'b0;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("abort_idle_busy", busy, 0);
    check("abort_queue_empty", exp_q.size(), 0);

    send(8'hFF, 1'b1, 0, 1'b0);

    repeat (50) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    check("response_count", n_resp, 8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte from the FPGA to the keyboard, e.g. 0xED set-LEDs or 0xFF reset. It complements the existing PS/2 receive path on the shared ps2_clock/ps2_data lines. It is instantiated beside the keyboard controller in the top level. Its busy output gates the receive path during transmission so host-driven bits are not decoded as scan codes.

## Interface
- INHIBIT_CYCLES, 6000: clock-low inhibit time in system clocks (120 µs at 50 MHz).
- FIRST_TIMEOUT, 750000: maximum wait for the device's first falling clock edge (15 ms).
- EDGE_TIMEOUT, 100000: maximum wait between later device clock edges, and for the final line release (2 ms).

- clock  in  1  system clock (CLOCK_50 domain); all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- send_data  in  8  byte to transmit; sampled on accepted send_req.
- send_req  in  1  one-cycle request; accepted only when busy=0.
- busy  out  1  high from the cycle after acceptance until done/error.
- done  out  1  one-cycle pulse: frame sent and device acknowledged.
- error  out  1  one-cycle pulse: timeout or missing ack.
- ps2_clk_in  in  1  raw ps2_clock pin level (asynchronous).
- ps2_data_in  in  1  raw ps2_data pin level (asynchronous).
- ps2_clk_oe  out  1  1 = drive ps2_clock low; 0 = release (open drain).
- ps2_data_oe  out  1  1 = drive ps2_data low; 0 = release.

## Operation
- ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer.
- A falling edge is one cycle where the synchronized clock was 1 last cycle and is 0 now.
- On acceptance:
  - Latch send_data.
  - Compute parity = ~^send_data (odd parity).
  - Clear bit counter (4 bits) and timeout counter (20 bits).
- States:
  - IDLE: all outputs 0.
    - send_req with busy=0 -> INHIBIT.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles.
    - Then -> REQ.
  - REQ: clk_oe=1, data_oe=1 (start bit 0) for exactly 1 cycle.
    - Then -> WAIT_FIRST.
  - WAIT_FIRST: clk_oe=0, data_oe=1.
    - First falling edge -> SHIFT, bit counter = 1, data_oe = ~data[0].
    - FIRST_TIMEOUT elapsed -> ERR.
  - SHIFT: the timeout counter restarts on every falling edge. Edges are numbered from the first; each edge k sets:
    - k = 2..8: data_oe = ~data[k-1].
    - k = 9: data_oe = ~parity.
    - k = 10: data_oe = 0 (stop bit, line released).
    - k = 11: sample synchronized data. 0 -> WAIT_IDLE; 1 -> ERR (no ack).
    - EDGE_TIMEOUT without an edge -> ERR.
  - WAIT_IDLE: wait until synchronized clock and data are both 1.
    - Then -> DONE.
    - EDGE_TIMEOUT elapsed -> ERR.
  - DONE: done=1 for one cycle -> IDLE.
  - ERR: error=1, both oe=0, for one cycle -> IDLE.
- busy=1 in every state except IDLE, DONE and ERR.
- send_req while busy=1 is ignored; the byte is not queued.
- done and error are never asserted together.

## Timing
- Reset value of every output is 0; both lines are released immediately (asynchronous).
- Reset mid-frame aborts with no done or error pulse. The device sees an incomplete frame and times out on its own.
- Accepted send_req at cycle 0:
  - busy=1 and clk_oe=1 from cycle 1.
  - clk_oe stays 1 through cycle INHIBIT_CYCLES+1.
  - data_oe rises at cycle INHIBIT_CYCLES+1.
  - clk_oe falls at cycle INHIBIT_CYCLES+2.
- data_oe changes 3 cycles after the physical falling edge on the pin: 2 synchronizer flops plus 1 register. This lands well inside the device's clock-low half period.
- Ack is sampled on edge 11 using the synchronized data level at that cycle.
- done/error assert 1 cycle after the terminating condition. busy drops in the same cycle.
- A new send_req is accepted in the cycle after done/error.
- Timeout comparisons are inclusive: exactly N cycles with no edge triggers ERR on cycle N.

## Test plan
- Send 0xED against a device model clocking at 12.5 kHz and acking. Required:
  - Device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done pulses once; busy is high throughout.
- Send 0x01 (parity 0), 0x00 (parity 1) and 0xFF (parity 1). The parity bit captured by the device matches each value and done pulses for each.
- Device model holds data high on clock 11 (no ack). Result: error pulses once, done stays 0, both oe are 0 afterwards.
- Device never clocks, with FIRST_TIMEOUT=50 and INHIBIT_CYCLES=10. Result: error exactly 50 cycles after clk_oe falls; data_oe released.
- Pulse send_req repeatedly during a frame with send_data=0x55. The frame still carries the original byte 0xED, and only one done appears.
- Assert reset after edge 5. All outputs go to 0 in the same cycle with no done/error. A following 0xFF request completes normally.
